audio_sample_packet_decoder: RTL and testbench

//  Sink-side audio packet decoder: opposite end of the audio sample / ACR packet builders.
//  - Takes decoded data-island packets (header + 4 subpackets, already BCH-checked) in the pixel clock domain.
//  - Unpacks 2-channel layout-0 Audio Sample Packets into a FWFT sample FIFO with valid/ready.
//  - Tracks IEC 60958 channel-status blocks and checks per-channel parity.

---
 rtl/audio_sample_packet_decoder.sv | 204 ++++++++++++++++++++
 tb/tb_audio_sample_packet_decoder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_packet_decoder.sv
// Sink-side audio sample packet decoder: unpacks layout-0 sample packets
// into a FWFT FIFO and tracks IEC 60958 channel-status blocks.
// Ports: clk_pixel/reset_n; packet_valid/header/sub packet input;
//   sample_out_valid/ready + audio_sample_word/valid_bit/parity_error head;
//   channel_status_left/right/update, cs_locked, overrun_count.
// Optional: AUDIO_ACR_CAPTURE_EN adds acr_n/acr_cts/acr_update.
module audio_sample_packet_decoder #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_pixel,
  input  logic        reset_n,
  input  logic        packet_valid,
  input  logic [23:0] header,
  input  logic [55:0] sub [3:0],
  output logic        sample_out_valid,
  input  logic        sample_out_ready,
  output logic [23:0] audio_sample_word [1:0],
  output logic [1:0]  sample_valid_bit,
  output logic [1:0]  sample_parity_error,
  output logic [39:0] channel_status_left,
  output logic [39:0] channel_status_right,
  output logic        channel_status_update,
  output logic        cs_locked,
  output logic [7:0]  overrun_count
`ifdef AUDIO_ACR_CAPTURE_EN
  ,
  output logic [19:0] acr_n,
  output logic [19:0] acr_cts,
  output logic        acr_update
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, UNPACK} state_t;

  state_t      state;
  logic [1:0]  idx;
  logic [3:0]  present;
  logic [3:0]  bflags;
  logic [55:0] hsub [3:0];

  logic [23:0] mem_l [FIFO_DEPTH];
  logic [23:0] mem_r [FIFO_DEPTH];
  logic [1:0]  mem_v [FIFO_DEPTH];
  logic [1:0]  mem_p [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  logic [7:0]  frame_cnt;
  logic        blk_start;
  logic [39:0] acc_l;
  logic [39:0] acc_r;

  logic [55:0] cur;
  logic        cur_present;
  logic        cur_b;
  logic        push;
  logic        pop;
  logic        full;
  logic        push_ok;
  logic        pkt_sample;
  logic        drop_pkt;
  logic [8:0]  ovf_sum;
  logic [7:0]  cs_nxt;
  logic        unused;

  assign unused = ^{header[19:16], header[15:13]};

  assign cur         = hsub[idx];
  assign cur_present = present[idx];
  assign cur_b       = bflags[idx];

  assign pkt_sample = packet_valid && header[7:0] == 8'd2
                      && !header[12];
  assign drop_pkt   = pkt_sample && state == UNPACK;

  assign push    = state == UNPACK && cur_present;
  assign pop     = sample_out_valid && sample_out_ready;
  assign full    = (wr_ptr - rd_ptr) == (AW + 1)'(FIFO_DEPTH);
  assign push_ok = push && (!full || pop);

  assign ovf_sum = {1'b0, overrun_count}
                 + {8'd0, drop_pkt}
                 + {8'd0, push && !push_ok};

  // Frame index this subpacket occupies inside the block.
  assign cs_nxt = cur_b ? 8'd0
                : (frame_cnt == 8'd191) ? 8'd0
                : frame_cnt + 8'd1;

  assign sample_out_valid     = wr_ptr != rd_ptr;
  assign audio_sample_word[0] = mem_l[rd_ptr[AW-1:0]];
  assign audio_sample_word[1] = mem_r[rd_ptr[AW-1:0]];
  assign sample_valid_bit     = mem_v[rd_ptr[AW-1:0]];
  assign sample_parity_error  = mem_p[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      idx     <= 2'd0;
      present <= 4'd0;
      bflags  <= 4'd0;
      for (int i = 0; i < 4; i++) hsub[i] <= 56'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pkt_sample) begin
            present <= header[11:8];
            bflags  <= header[23:20];
            for (int i = 0; i < 4; i++) hsub[i] <= sub[i];
            idx     <= 2'd0;
            state   <= UNPACK;
          end
        end
        UNPACK: begin
          idx <= idx + 2'd1;
          if (idx == 2'd3) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      overrun_count <= 8'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_l[i] <= 24'd0;
        mem_r[i] <= 24'd0;
        mem_v[i] <= 2'd0;
        mem_p[i] <= 2'd0;
      end
    end else begin
      if (push_ok) begin
        mem_l[wr_ptr[AW-1:0]] <= cur[23:0];
        mem_r[wr_ptr[AW-1:0]] <= cur[47:24];
        mem_v[wr_ptr[AW-1:0]] <= {cur[52], cur[48]};
        mem_p[wr_ptr[AW-1:0]] <= {^{cur[55:52], cur[47:24]},
                                  ^{cur[51:48], cur[23:0]}};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      overrun_count <= ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt             <= 8'd0;
      blk_start             <= 1'b0;
      acc_l                 <= 40'd0;
      acc_r                 <= 40'd0;
      channel_status_left   <= 40'd0;
      channel_status_right  <= 40'd0;
      channel_status_update <= 1'b0;
      cs_locked             <= 1'b0;
    end else begin
      channel_status_update <= 1'b0;
      if (push) begin
        frame_cnt <= cs_nxt;
        if (cur_b) begin
          if (frame_cnt == 8'd191 && (cs_locked || blk_start)) begin
            channel_status_left   <= acc_l;
            channel_status_right  <= acc_r;
            channel_status_update <= 1'b1;
            cs_locked             <= 1'b1;
          end else if (frame_cnt != 8'd191) begin
            cs_locked <= 1'b0;
          end
          blk_start <= 1'b1;
        end else if (frame_cnt == 8'd191) begin
          // Block ran long without a B: drop framing until next B.
          cs_locked <= 1'b0;
          blk_start <= 1'b0;
        end
        if (cs_nxt < 8'd40) begin
          acc_l[cs_nxt[5:0]] <= cur[50];
          acc_r[cs_nxt[5:0]] <= cur[54];
        end
      end
    end
  end

`ifdef AUDIO_ACR_CAPTURE_EN
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      acr_n      <= 20'd0;
      acr_cts    <= 20'd0;
      acr_update <= 1'b0;
    end else begin
      acr_update <= 1'b0;
      if (packet_valid && header[7:0] == 8'd1) begin
        acr_n      <= {sub[0][35:32], sub[0][47:40], sub[0][55:48]};
        acr_cts    <= {sub[0][11:8], sub[0][23:16], sub[0][31:24]};
        acr_update <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_audio_sample_packet_decoder.sv
// Directed self-checking bench for audio_sample_packet_decoder.
// Optional ACR checks follow AUDIO_ACR_CAPTURE_EN.
module tb_audio_sample_packet_decoder;

  logic        clk_pixel = 1'b0;
  logic        reset_n;
  logic        packet_valid;
  logic [23:0] header;
  logic [55:0] sub [3:0];
  logic        sample_out_valid;
  logic        sample_out_ready;
  logic [23:0] audio_sample_word [1:0];
  logic [1:0]  sample_valid_bit;
  logic [1:0]  sample_parity_error;
  logic [39:0] channel_status_left;
  logic [39:0] channel_status_right;
  logic        channel_status_update;
  logic        cs_locked;
  logic [7:0]  overrun_count;
`ifdef AUDIO_ACR_CAPTURE_EN
  logic [19:0] acr_n;
  logic [19:0] acr_cts;
  logic        acr_update;
`endif

  int ncmp = 0;
  int nfail = 0;
  int upd_cnt = 0;

  always #5 clk_pixel = ~clk_pixel;

  audio_sample_packet_decoder #(.FIFO_DEPTH(8)) dut (
    .clk_pixel(clk_pixel),
    .reset_n(reset_n),
    .packet_valid(packet_valid),
    .header(header),
    .sub(sub),
    .sample_out_valid(sample_out_valid),
    .sample_out_ready(sample_out_ready),
    .audio_sample_word(audio_sample_word),
    .sample_valid_bit(sample_valid_bit),
    .sample_parity_error(sample_parity_error),
    .channel_status_left(channel_status_left),
    .channel_status_right(channel_status_right),
    .channel_status_update(channel_status_update),
    .cs_locked(cs_locked),
    .overrun_count(overrun_count)
`ifdef AUDIO_ACR_CAPTURE_EN
    ,
    .acr_n(acr_n),
    .acr_cts(acr_cts),
    .acr_update(acr_update)
`endif
  );

  always @(negedge clk_pixel)
    if (channel_status_update === 1'b1) upd_cnt++;

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Subpacket with even parity per channel; flip inverts Pl.
  function automatic logic [55:0] mk(input logic [23:0] l,
                                     input logic [23:0] r,
                                     input logic cl, input logic cr,
                                     input logic vl, input logic vr,
                                     input logic flip);
    logic pl, pr;
    pl = (^{cl, vl, l}) ^ flip;
    pr = ^{cr, vr, r};
    return {pr, cr, 1'b0, vr, pl, cl, 1'b0, vl, r, l};
  endfunction

  task automatic send(input logic [23:0] h,
                      input logic [55:0] s0, input logic [55:0] s1,
                      input logic [55:0] s2, input logic [55:0] s3);
    header = h;
    sub[0] = s0;
    sub[1] = s1;
    sub[2] = s2;
    sub[3] = s3;
    packet_valid = 1'b1;
    tick();
    packet_valid = 1'b0;
  endtask

  initial begin
    logic [39:0] pat;
    logic        c;
    pat = 40'h0000_0200_04;
    reset_n = 1'b0;
    packet_valid = 1'b0;
    header = 24'd0;
    for (int i = 0; i < 4; i++) sub[i] = 56'd0;
    sample_out_ready = 1'b0;
    ticks(3);

    chk("rst_valid", 64'(sample_out_valid), 64'd0);
    chk("rst_word0", 64'(audio_sample_word[0]), 64'd0);
    chk("rst_cs_l", 64'(channel_status_left), 64'd0);
    chk("rst_lock", 64'(cs_locked), 64'd0);
    chk("rst_ovf", 64'(overrun_count), 64'd0);
    reset_n = 1'b1;
    tick();

    // Single sample, drains immediately.
    sample_out_ready = 1'b1;
    send(24'h10_01_02,
         mk(24'h123456, 24'hABCDEF, 0, 0, 0, 0, 0), 56'd0, 56'd0, 56'd0);
    chk("t1_lat1", 64'(sample_out_valid), 64'd0);
    tick();
    chk("t1_valid", 64'(sample_out_valid), 64'd1);
    chk("t1_left", 64'(audio_sample_word[0]), 64'h123456);
    chk("t1_right", 64'(audio_sample_word[1]), 64'hABCDEF);
    chk("t1_perr", 64'(sample_parity_error), 64'd0);
    tick();
    chk("t1_empty", 64'(sample_out_valid), 64'd0);
    ticks(3);

    // Fill FIFO with four 4-sample packets, ready low.
    sample_out_ready = 1'b0;
    for (int p = 0; p < 4; p++) begin
      send(24'h00_0F_02,
           mk(24'h100000 + 24'(4*p+0), 24'h200000 + 24'(4*p+0), 0,0,0,0,0),
           mk(24'h100000 + 24'(4*p+1), 24'h200000 + 24'(4*p+1), 0,0,0,0,0),
           mk(24'h100000 + 24'(4*p+2), 24'h200000 + 24'(4*p+2), 0,0,0,0,0),
           mk(24'h100000 + 24'(4*p+3), 24'h200000 + 24'(4*p+3), 0,0,0,0,0));
      ticks(4);
    end
    chk("t2_ovf", 64'(overrun_count), 64'd8);
    chk("t2_valid", 64'(sample_out_valid), 64'd1);
    sample_out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t2_l%0d", k), 64'(audio_sample_word[0]),
          64'h100000 + 64'(k));
      chk($sformatf("t2_r%0d", k), 64'(audio_sample_word[1]),
          64'h200000 + 64'(k));
      tick();
    end
    chk("t2_empty", 64'(sample_out_valid), 64'd0);

    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("t3_ovf_rst", 64'(overrun_count), 64'd0);

    // One full 192-frame block, then closing B.
    for (int f = 0; f < 192; f++) begin
      c = 1'b0;
      if (f < 40) c = pat[f];
      send(f == 0 ? 24'h10_01_02 : 24'h00_01_02,
           mk(24'(f), 24'(f + 1000), c, 0, 0, 0, 0), 56'd0, 56'd0, 56'd0);
      ticks(4);
    end
    chk("t3_lock_pre", 64'(cs_locked), 64'd0);
    chk("t3_upd_pre", 64'(upd_cnt), 64'd0);
    send(24'h10_01_02, mk(24'd5, 24'd6, 0, 0, 0, 0, 0),
         56'd0, 56'd0, 56'd0);
    ticks(4);
    chk("t3_cs_l", 64'(channel_status_left), 64'h0000_0200_04);
    chk("t3_cs_r", 64'(channel_status_right), 64'd0);
    chk("t3_upd", 64'(upd_cnt), 64'd1);
    chk("t3_lock", 64'(cs_locked), 64'd1);

    // Parity flip on left of first entry only.
    sample_out_ready = 1'b0;
    send(24'h00_03_02,
         mk(24'h0A0A0A, 24'h0B0B0B, 0, 0, 0, 0, 1),
         mk(24'h0C0C0C, 24'h0D0D0D, 0, 0, 1, 0, 0),
         56'd0, 56'd0);
    ticks(4);
    chk("t4_perr0", 64'(sample_parity_error), 64'h1);
    chk("t4_word0", 64'(audio_sample_word[0]), 64'h0A0A0A);
    sample_out_ready = 1'b1;
    tick();
    chk("t4_perr1", 64'(sample_parity_error), 64'h0);
    chk("t4_vbit1", 64'(sample_valid_bit), 64'h1);
    tick();
    chk("t4_empty", 64'(sample_out_valid), 64'd0);
    // Frames 3..99, then B lands at frame 100.
    for (int f = 3; f < 100; f++) begin
      send(24'h00_01_02, mk(24'(f), 24'(f), 0, 0, 0, 0, 0),
           56'd0, 56'd0, 56'd0);
      ticks(4);
    end
    chk("t4_lock_pre", 64'(cs_locked), 64'd1);
    send(24'h10_01_02, mk(24'd1, 24'd2, 0, 0, 0, 0, 0),
         56'd0, 56'd0, 56'd0);
    ticks(4);
    chk("t4_unlock", 64'(cs_locked), 64'd0);
    chk("t4_no_upd", 64'(upd_cnt), 64'd1);
    chk("t4_cs_hold", 64'(channel_status_left), 64'h0000_0200_04);

    // Packet arriving while busy is dropped.
    chk("t5_ovf0", 64'(overrun_count), 64'd0);
    send(24'h00_01_02, mk(24'd7, 24'd8, 0, 0, 0, 0, 0),
         56'd0, 56'd0, 56'd0);
    tick();
    send(24'h00_01_02, mk(24'd9, 24'd9, 0, 0, 0, 0, 0),
         56'd0, 56'd0, 56'd0);
    chk("t5_ovf1", 64'(overrun_count), 64'd1);
    ticks(4);

    // Reset while unpacking clears everything.
    sample_out_ready = 1'b0;
    send(24'h00_0F_02,
         mk(24'd11, 24'd12, 0, 0, 0, 0, 0),
         mk(24'd13, 24'd14, 0, 0, 0, 0, 0),
         mk(24'd15, 24'd16, 0, 0, 0, 0, 0),
         mk(24'd17, 24'd18, 0, 0, 0, 0, 0));
    tick();
    chk("t5_partial", 64'(sample_out_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(sample_out_valid), 64'd0);
    chk("t5_rst_word", 64'(audio_sample_word[0]), 64'd0);
    chk("t5_rst_ovf", 64'(overrun_count), 64'd0);
    chk("t5_rst_cs", 64'(channel_status_left), 64'd0);
    ticks(2);
    reset_n = 1'b1;
    ticks(6);
    chk("t5_no_resid", 64'(sample_out_valid), 64'd0);

`ifdef AUDIO_ACR_CAPTURE_EN
    // N=6144 (0x01800), CTS=74250 (0x1220A).
    send(24'h00_00_01,
         {8'h00, 8'h18, 4'h0, 4'h0, 8'h0A, 8'h22, 4'h0, 4'h1, 8'h00},
         56'd0, 56'd0, 56'd0);
    chk("t6_n", 64'(acr_n), 64'd6144);
    chk("t6_cts", 64'(acr_cts), 64'd74250);
    chk("t6_upd", 64'(acr_update), 64'd1);
    tick();
    chk("t6_upd_off", 64'(acr_update), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
